// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity mode codes, the
// receiver state encoding and the parity helper used by the receiver.
package uart_pkg;

  localparam int unsigned PARITY_NONE   = 32'd0;
  localparam int unsigned PARITY_EVEN   = 32'd1;
  localparam int unsigned PARITY_ODD    = 32'd2;
  localparam int unsigned MAX_DATA_BITS = 32'd9;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } rx_state_t;

  // Parity bit the transmitter should have sent for a word; unused upper
  // bits must be zero so they do not disturb the XOR reduction.
  function automatic logic expected_parity(input logic [MAX_DATA_BITS-1:0] data,
                                           input logic odd);
    logic p;
    p = ^data;
    if (odd) begin
      expected_parity = ~p;
    end else begin
      expected_parity = p;
    end
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input line.
// Both flops reset to 1 so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage resynchronisation into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: oversampled start-bit validation, mid-bit sampling
// of DATA_BITS data bits, optional parity and 1..2 stop bits. A completed
// word is held behind a valid/ready handshake; a frame arriving while the
// previous word is still unread is dropped and flagged as overrun.
module uart_rx_core #(
  parameter int unsigned DATA_BITS   = 32'd8,
  parameter int unsigned OVERSAMPLE  = 32'd16,
  parameter int unsigned PARITY_MODE = 32'd0,
  parameter int unsigned STOP_BITS   = 32'd1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  import uart_pkg::*;

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 32'd1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((OVERSAMPLE / 32'd2) - 32'd1);
  localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(32'd0);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(32'd1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 32'd1);

  localparam logic HAS_PARITY    = (PARITY_MODE != PARITY_NONE);
  localparam logic ODD_PARITY    = (PARITY_MODE == PARITY_ODD);
  localparam logic STOP_LAST_IDX = (STOP_BITS == 32'd2);

  // Synchronised copy of the serial line; every decision below uses it.
  logic rx_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  rx_state_t            state_r, state_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [BIT_W-1:0]     bit_idx_r, bit_idx_s;
  logic [DATA_BITS-1:0] shreg_r, shreg_s;
  logic                 perr_r, perr_s;
  logic                 ferr_r, ferr_s;
  logic                 stop_idx_r, stop_idx_s;
  logic                 done_s;
  logic [MAX_DATA_BITS-1:0] par_data_s;

  logic busy_s;
  logic load_s;
  logic drop_s;
  logic ack_s;

  // FSM state and receive datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      bit_idx_r  <= BIT_ZERO;
      shreg_r    <= {DATA_BITS{1'b0}};
      perr_r     <= 1'b0;
      ferr_r     <= 1'b0;
      stop_idx_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      bit_idx_r  <= bit_idx_s;
      shreg_r    <= shreg_s;
      perr_r     <= perr_s;
      ferr_r     <= ferr_s;
      stop_idx_r <= stop_idx_s;
    end
  end

  // Next-state and datapath update; samples are taken only on ticks.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    bit_idx_s  = bit_idx_r;
    shreg_s    = shreg_r;
    perr_s     = perr_r;
    ferr_s     = ferr_r;
    stop_idx_s = stop_idx_r;
    done_s     = 1'b0;
    par_data_s = {MAX_DATA_BITS{1'b0}};
    par_data_s[DATA_BITS-1:0] = shreg_r;

    case (state_r)
      IDLE: begin
        if (tick && !rx_s) begin
          state_s = START;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = IDLE;
        end
      end

      START: begin
        if (tick) begin
          if (cnt_r == CNT_HALF) begin
            cnt_s = CNT_ZERO;
            if (!rx_s) begin
              // Start bit still low at its centre: a real frame.
              state_s    = DATA;
              bit_idx_s  = BIT_ZERO;
              perr_s     = 1'b0;
              ferr_s     = 1'b0;
              stop_idx_s = 1'b0;
            end else begin
              // Line recovered before mid-bit: treat as a glitch.
              state_s = IDLE;
            end
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end

      DATA: begin
        if (tick) begin
          if (cnt_r == CNT_LAST) begin
            cnt_s   = CNT_ZERO;
            shreg_s = {rx_s, shreg_r[DATA_BITS-1:1]};
            if (bit_idx_r == BIT_LAST) begin
              state_s = HAS_PARITY ? PARITY : STOP;
            end else begin
              bit_idx_s = bit_idx_r + BIT_ONE;
            end
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end

      PARITY: begin
        if (tick) begin
          if (cnt_r == CNT_LAST) begin
            cnt_s   = CNT_ZERO;
            state_s = STOP;
            if (rx_s != expected_parity(par_data_s, ODD_PARITY)) begin
              perr_s = 1'b1;
            end else begin
              perr_s = perr_r;
            end
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end

      STOP: begin
        if (tick) begin
          if (cnt_r == CNT_LAST) begin
            cnt_s = CNT_ZERO;
            if (!rx_s) begin
              ferr_s = 1'b1;
            end else begin
              ferr_s = ferr_r;
            end
            if (stop_idx_r == STOP_LAST_IDX) begin
              done_s = 1'b1;
              // A line still low at the final stop sample is a break;
              // park until it releases so it yields a single frame.
              if (ferr_s && !rx_s) begin
                state_s = BRK_WAIT;
              end else begin
                state_s = IDLE;
              end
            end else begin
              stop_idx_s = 1'b1;
            end
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end

      BRK_WAIT: begin
        if (rx_s) begin
          state_s = IDLE;
        end else begin
          state_s = BRK_WAIT;
        end
      end

      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Output-side decode: busy level and handshake/completion events.
  always_comb begin
    busy_s = (state_s != IDLE);
    ack_s  = rx_valid && rx_ready;
    load_s = done_s && (!rx_valid || rx_ready);
    drop_s = done_s && rx_valid && !rx_ready;
  end

  // Held word, flags and handshake state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data    <= {DATA_BITS{1'b0}};
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy <= busy_s;
      if (load_s) begin
        rx_data    <= shreg_r;
        parity_err <= perr_r;
        frame_err  <= ferr_s;
        rx_valid   <= 1'b1;
        if (ack_s) begin
          overrun <= 1'b0;
        end else begin
          overrun <= overrun;
        end
      end else if (drop_s) begin
        overrun <= 1'b1;
      end else if (ack_s) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end else begin
        rx_valid <= rx_valid;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: four instances (8N1, 8E1, 8O1, 7N2) share
// the serial line, tick is tied high and each bit lasts 16 clk.
module tb_uart_rx_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b1;
  logic rx = 1'b1;
  logic rx_ready = 1'b1;

  always #5 clk = ~clk;

  logic [7:0] a_data, e_data, o_data;
  logic [6:0] s_data;
  logic a_valid, a_perr, a_ferr, a_ovr, a_busy;
  logic e_valid, e_perr, e_ferr, e_ovr, e_busy;
  logic o_valid, o_perr, o_ferr, o_ovr, o_busy;
  logic s_valid, s_perr, s_ferr, s_ovr, s_busy;

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx), .rx_data(a_data), .rx_valid(a_valid),
    .rx_ready(rx_ready), .parity_err(a_perr), .frame_err(a_ferr), .overrun(a_ovr), .busy(a_busy));
  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx), .rx_data(e_data), .rx_valid(e_valid),
    .rx_ready(rx_ready), .parity_err(e_perr), .frame_err(e_ferr), .overrun(e_ovr), .busy(e_busy));
  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(2), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx), .rx_data(o_data), .rx_valid(o_valid),
    .rx_ready(rx_ready), .parity_err(o_perr), .frame_err(o_ferr), .overrun(o_ovr), .busy(o_busy));
  uart_rx_core #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx), .rx_data(s_data), .rx_valid(s_valid),
    .rx_ready(rx_ready), .parity_err(s_perr), .frame_err(s_ferr), .overrun(s_ovr), .busy(s_busy));

  // Selected instance outputs.
  int sel = 0;
  logic [8:0] sel_data;
  logic sel_valid, sel_perr, sel_ferr, sel_ovr, sel_busy;

  always_comb begin
    case (sel)
      1: begin sel_data = {1'b0, e_data}; sel_valid = e_valid; sel_perr = e_perr; sel_ferr = e_ferr; sel_ovr = e_ovr; sel_busy = e_busy; end
      2: begin sel_data = {1'b0, o_data}; sel_valid = o_valid; sel_perr = o_perr; sel_ferr = o_ferr; sel_ovr = o_ovr; sel_busy = o_busy; end
      3: begin sel_data = {2'b00, s_data}; sel_valid = s_valid; sel_perr = s_perr; sel_ferr = s_ferr; sel_ovr = s_ovr; sel_busy = s_busy; end
      default: begin sel_data = {1'b0, a_data}; sel_valid = a_valid; sel_perr = a_perr; sel_ferr = a_ferr; sel_ovr = a_ovr; sel_busy = a_busy; end
    endcase
  end

  // Capture every word handed over by the selected instance.
  int cap_cnt = 0;
  logic [8:0] cap_data = 9'h000;
  logic cap_perr = 1'b0;
  logic cap_ferr = 1'b0;
  logic cap_ovr = 1'b0;

  always @(negedge clk) begin
    if (sel_valid && rx_ready) begin
      cap_cnt  <= cap_cnt + 1;
      cap_data <= sel_data;
      cap_perr <= sel_perr;
      cap_ferr <= sel_ferr;
      cap_ovr  <= sel_ovr;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [8:0] data, input int ndata, input bit has_par,
                            input bit par, input int nstop, input bit s0, input bit s1);
    drive_bit(1'b0, 16);
    for (int i = 0; i < ndata; i++) drive_bit(data[i], 16);
    if (has_par) drive_bit(par, 16);
    drive_bit(s0, 16);
    if (nstop == 2) drive_bit(s1, 16);
    rx = 1'b1;
  endtask

  // Start bit plus three data bits and half of bit 3, then reset mid-frame.
  task automatic reset_mid(input logic [8:0] partial, input string tag);
    drive_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) drive_bit(partial[i], 16);
    drive_bit(partial[3], 8);
    check({tag, "_busy_before_rst"}, sel_busy, 1);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check({tag, "_rst_valid"}, sel_valid, 0);
    check({tag, "_rst_data"}, sel_data, 0);
    check({tag, "_rst_perr"}, sel_perr, 0);
    check({tag, "_rst_ferr"}, sel_ferr, 0);
    check({tag, "_rst_ovr"}, sel_ovr, 0);
    check({tag, "_rst_busy"}, sel_busy, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    int         dut;
    logic [8:0] data;
    int         ndata;
    bit         has_par;
    bit         par;
    int         nstop;
    bit         s0;
    bit         s1;
    logic [8:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
  } vec_t;

  vec_t vecs[10];
  int base;
  int lat;
  int bc;
  logic b2, b3, bmid;

  initial begin
    vecs[0] = '{0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 9'h0A5, 1'b0, 1'b0};
    vecs[1] = '{0, 9'h000, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0};
    vecs[2] = '{0, 9'h0FF, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 9'h0FF, 1'b0, 1'b0};
    vecs[3] = '{0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b0, 1'b1, 9'h03C, 1'b0, 1'b1};
    vecs[4] = '{1, 9'h03C, 8, 1'b1, 1'b1, 1, 1'b1, 1'b1, 9'h03C, 1'b1, 1'b0};
    vecs[5] = '{1, 9'h03C, 8, 1'b1, 1'b0, 1, 1'b1, 1'b1, 9'h03C, 1'b0, 1'b0};
    vecs[6] = '{2, 9'h03C, 8, 1'b1, 1'b1, 1, 1'b1, 1'b1, 9'h03C, 1'b0, 1'b0};
    vecs[7] = '{2, 9'h007, 8, 1'b1, 1'b1, 1, 1'b1, 1'b1, 9'h007, 1'b1, 1'b0};
    vecs[8] = '{3, 9'h055, 7, 1'b0, 1'b0, 2, 1'b1, 1'b1, 9'h055, 1'b0, 1'b0};
    vecs[9] = '{3, 9'h055, 7, 1'b0, 1'b0, 2, 1'b1, 1'b0, 9'h055, 1'b0, 1'b1};

    // Reset state.
    sel = 0;
    do_reset();
    check("reset_valid", sel_valid, 0);
    check("reset_data", sel_data, 0);
    check("reset_perr", sel_perr, 0);
    check("reset_ferr", sel_ferr, 0);
    check("reset_ovr", sel_ovr, 0);
    check("reset_busy", sel_busy, 0);

    // Table-driven frames.
    for (int i = 0; i < 10; i++) begin
      sel = vecs[i].dut;
      do_reset();
      base = cap_cnt;
      send_frame(vecs[i].data, vecs[i].ndata, vecs[i].has_par, vecs[i].par,
                 vecs[i].nstop, vecs[i].s0, vecs[i].s1);
      repeat (40) @(negedge clk);
      check($sformatf("v%0d_words", i), cap_cnt - base, 1);
      check($sformatf("v%0d_data", i), cap_data, vecs[i].exp_data);
      check($sformatf("v%0d_perr", i), cap_perr, vecs[i].exp_perr);
      check($sformatf("v%0d_ferr", i), cap_ferr, vecs[i].exp_ferr);
      check($sformatf("v%0d_ovr", i), cap_ovr, 0);
      check($sformatf("v%0d_valid_after", i), sel_valid, 0);
      check($sformatf("v%0d_busy_after", i), sel_busy, 0);
    end

    // Latency from start edge to rx_valid, and busy rise timing.
    sel = 0;
    do_reset();
    base = cap_cnt;
    lat = 0;
    fork
      send_frame(9'h096, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
      begin
        while (!sel_valid && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
      begin
        repeat (2) @(negedge clk);
        b2 = sel_busy;
        @(negedge clk);
        b3 = sel_busy;
        repeat (50) @(negedge clk);
        bmid = sel_busy;
      end
    join
    repeat (40) @(negedge clk);
    check("lat_valid_cycles", lat, 155);
    check("lat_busy_before_detect", b2, 0);
    check("lat_busy_after_detect", b3, 1);
    check("lat_busy_mid_frame", bmid, 1);
    check("lat_words", cap_cnt - base, 1);
    check("lat_data", cap_data, 9'h096);

    // Short low glitch: no word, busy drops quickly.
    do_reset();
    base = cap_cnt;
    bc = 0;
    rx = 1'b0;
    for (int i = 0; i < 44; i++) begin
      if (i == 4) rx = 1'b1;
      @(negedge clk);
      if (sel_busy) bc++;
    end
    check("glitch_words", cap_cnt - base, 0);
    check("glitch_busy_bound", (bc >= 1 && bc <= 12), 1);
    check("glitch_busy_end", sel_busy, 0);

    // Held break: exactly one all-zero word with frame_err.
    do_reset();
    base = cap_cnt;
    drive_bit(1'b0, 640);
    check("break_busy_held", sel_busy, 1);
    drive_bit(1'b1, 48);
    check("break_words", cap_cnt - base, 1);
    check("break_data", cap_data, 0);
    check("break_ferr", cap_ferr, 1);
    check("break_busy_released", sel_busy, 0);
    send_frame(9'h081, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    repeat (40) @(negedge clk);
    check("after_break_words", cap_cnt - base, 2);
    check("after_break_data", cap_data, 9'h081);
    check("after_break_ferr", cap_ferr, 0);

    // Overrun: second frame dropped while the first is unread.
    @(negedge clk);
    rst_n = 1'b0;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    base = cap_cnt;
    send_frame(9'h011, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    drive_bit(1'b1, 16);
    check("ovr_first_valid", sel_valid, 1);
    check("ovr_first_flag", sel_ovr, 0);
    send_frame(9'h022, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    repeat (32) @(negedge clk);
    check("ovr_valid_held", sel_valid, 1);
    check("ovr_data_kept", sel_data, 9'h011);
    check("ovr_flag", sel_ovr, 1);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovr_ack_valid", sel_valid, 0);
    check("ovr_ack_flag", sel_ovr, 0);
    check("ovr_ack_words", cap_cnt - base, 1);
    check("ovr_ack_data", cap_data, 9'h011);

    // Reset during a frame, then a clean frame (8N1).
    reset_mid(9'h05A, "rst8");
    base = cap_cnt;
    send_frame(9'h0C3, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    repeat (40) @(negedge clk);
    check("rst8_words", cap_cnt - base, 1);
    check("rst8_data", cap_data, 9'h0C3);
    check("rst8_perr", cap_perr, 0);
    check("rst8_ferr", cap_ferr, 0);

    // Same on the 7-bit, 2-stop instance with a low second stop bit.
    sel = 3;
    do_reset();
    reset_mid(9'h05A, "rst7");
    base = cap_cnt;
    send_frame(9'h055, 7, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    check("rst7_words", cap_cnt - base, 1);
    check("rst7_data", cap_data, 9'h055);
    check("rst7_ferr", cap_ferr, 1);
    check("rst7_perr", cap_perr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
